// File: rtl/voice_mixer_pkg.sv
// synth_pkg: shared widths, saturation limits and FSM state encoding for
// the voice_mixer slice (top, output interface and mixer_sat clamp).
package synth_pkg;

   localparam int SAMPLE_W = 16;
   localparam int VOL_W    = 16;
   localparam int MVOL_W   = 8;
   localparam int N_VOICE  = 4;

   // Accumulator holds the sum of four SAMPLE_W+1 bit scaled voices.
   localparam int ACC_W = 19;
   // Master-scaled intermediate, one bit wider than the accumulator.
   localparam int MST_W = 20;

   localparam logic signed [MST_W-1:0] SAT_MAX = 20'sd32767;
   localparam logic signed [MST_W-1:0] SAT_MIN = -20'sd32768;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MAC    = 3'd1,
      S_MASTER = 3'd2,
      S_SAT    = 3'd3,
      S_OUT    = 3'd4
   } state_e;

endpackage

// File: rtl/voice_mixer_if.sv
// voice_mixer_if: mixed-sample output port towards the codec serializer.
// Handshake: mix_valid high means mix_out holds an unconsumed sample; the
// producer keeps mix_out and mix_valid stable until a cycle where
// mix_valid && mix_ready, which is the single transfer cycle. mix_ready has
// no meaning while mix_valid is low.
interface voice_mixer_if;
   import synth_pkg::*;

   logic signed [SAMPLE_W-1:0] mix_out;
   logic                       mix_valid;
   logic                       mix_ready;

   modport master (output mix_out, output mix_valid, input mix_ready);
   modport slave  (input mix_out, input mix_valid, output mix_ready);

endinterface

// File: rtl/voice_mixer_sat.sv
// mixer_sat: combinational signed clamp from MST_W bits down to SAMPLE_W.
module mixer_sat
   import synth_pkg::*;
(
   input  logic signed [MST_W-1:0]    din,
   output logic signed [SAMPLE_W-1:0] dout
);

   // Clamp to the representable SAMPLE_W range, otherwise pass through.
   always_comb begin
      dout = din[SAMPLE_W-1:0];
      if (din > SAT_MAX) begin
         dout = SAT_MAX[SAMPLE_W-1:0];
      end else if (din < SAT_MIN) begin
         dout = SAT_MIN[SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: four-voice mixer with per-note and master volume, one shared
// multiplier sequenced by an IDLE/MAC/MASTER/SAT/OUT FSM.
// Optional feature macro: VOICE_MIXER_VOL_SMOOTH_EN -- when defined the
// master gain ramps by one LSB per accepted tick towards master_vol.
module voice_mixer
   import synth_pkg::*;
(
   input  logic                       clk_clk,
   input  logic                       reset_reset_n,
   input  logic                       sample_tick,
   input  logic signed [SAMPLE_W-1:0] voice_0,
   input  logic signed [SAMPLE_W-1:0] voice_1,
   input  logic signed [SAMPLE_W-1:0] voice_2,
   input  logic signed [SAMPLE_W-1:0] voice_3,
   input  logic        [VOL_W-1:0]    note_vol_0,
   input  logic        [VOL_W-1:0]    note_vol_1,
   input  logic        [VOL_W-1:0]    note_vol_2,
   input  logic        [VOL_W-1:0]    note_vol_3,
   input  logic        [MVOL_W-1:0]   master_vol,
   voice_mixer_if.master              mix_if,
   output logic                       overrun,
   input  logic                       clr_overrun,
   output logic        [2:0]          dbg_state
);

   localparam logic [2:0] IDLE   = S_IDLE;
   localparam logic [2:0] MAC    = S_MAC;
   localparam logic [2:0] MASTER = S_MASTER;
   localparam logic [2:0] SAT    = S_SAT;
   localparam logic [2:0] OUT    = S_OUT;

   logic [2:0]                 state;
   logic [1:0]                 idx;
   logic signed [ACC_W-1:0]    acc;
   logic signed [MST_W-1:0]    mst;
   logic signed [SAMPLE_W-1:0] voice_q [N_VOICE];
   logic        [VOL_W-1:0]    vol_q   [N_VOICE];
   logic        [MVOL_W-1:0]   gain;

   logic                       take;
   logic                       drop;
   logic signed [ACC_W-1:0]    mul_a;
   logic signed [VOL_W:0]      mul_b;
   logic signed [ACC_W+VOL_W:0] prod;
   logic signed [SAMPLE_W-1:0] sat_out;

   assign dbg_state = state;

   // A tick is taken in IDLE or on the OUT handshake cycle; anywhere else it is lost.
   assign take = sample_tick && ((state == IDLE) || ((state == OUT) && mix_if.mix_ready));
   assign drop = sample_tick && !take;

   // Shared multiplier: voice*note_vol during MAC, acc*gain during MASTER.
   always_comb begin
      mul_a = ACC_W'(voice_q[idx]);
      mul_b = {1'b0, vol_q[idx]};
      if (state == MASTER) begin
         mul_a = acc;
         mul_b = {{(VOL_W + 1 - MVOL_W){1'b0}}, gain};
      end
      prod = mul_a * mul_b;
   end

   mixer_sat u_sat (
      .din  (mst),
      .dout (sat_out)
   );

   // Input capture on every accepted tick; only these values feed the math.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < N_VOICE; i++) begin
            voice_q[i] <= '0;
            vol_q[i]   <= '0;
         end
      end else if (take) begin
         voice_q[0] <= voice_0;
         voice_q[1] <= voice_1;
         voice_q[2] <= voice_2;
         voice_q[3] <= voice_3;
         vol_q[0]   <= note_vol_0;
         vol_q[1]   <= note_vol_1;
         vol_q[2]   <= note_vol_2;
         vol_q[3]   <= note_vol_3;
      end
   end

`ifdef VOICE_MIXER_VOL_SMOOTH_EN
   // Master gain slews one LSB per accepted tick towards master_vol.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         gain <= '0;
      end else if (take) begin
         if (gain < master_vol) begin
            gain <= gain + 1'b1;
         end else if (gain > master_vol) begin
            gain <= gain - 1'b1;
         end
      end
   end
`else
   // Master gain is simply master_vol as captured at the accepted tick.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         gain <= '0;
      end else if (take) begin
         gain <= master_vol;
      end
   end
`endif

   // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   // Sequencer: MAC over four voices, master scale, clamp, then hold for the handshake.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state            <= IDLE;
         idx              <= '0;
         acc              <= '0;
         mst              <= '0;
         mix_if.mix_out   <= '0;
         mix_if.mix_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            MAC: begin
               acc <= acc + ACC_W'(prod >>> VOL_W);
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state <= MASTER;
               end
            end
            MASTER: begin
               mst   <= MST_W'(prod >>> MVOL_W);
               state <= SAT;
            end
            SAT: begin
               mix_if.mix_out   <= sat_out;
               mix_if.mix_valid <= 1'b1;
               state            <= OUT;
            end
            OUT: begin
               if (mix_if.mix_ready) begin
                  mix_if.mix_valid <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // An accepted tick overrides the IDLE/OUT exits and starts a new sample.
         if (take) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
         end
      end
   end

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed bench for voice_mixer with an expected-sample
// queue filled at each accepted tick and drained on each output handshake.
module tb_voice_mixer;

   logic               clk_clk = 1'b0;
   logic               reset_reset_n = 1'b0;
   logic               sample_tick = 1'b0;
   logic               clr_overrun = 1'b0;
   logic signed [15:0] voice [4];
   logic        [15:0] note_vol [4];
   logic        [7:0]  master_vol = 8'd0;
   logic               overrun;
   logic        [2:0]  dbg_state;

   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          model_gain = 0;

   voice_mixer_if bus ();

   voice_mixer dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .sample_tick   (sample_tick),
      .voice_0       (voice[0]),
      .voice_1       (voice[1]),
      .voice_2       (voice[2]),
      .voice_3       (voice[3]),
      .note_vol_0    (note_vol[0]),
      .note_vol_1    (note_vol[1]),
      .note_vol_2    (note_vol[2]),
      .note_vol_3    (note_vol[3]),
      .master_vol    (master_vol),
      .mix_if        (bus),
      .overrun       (overrun),
      .clr_overrun   (clr_overrun),
      .dbg_state     (dbg_state)
   );

   // Clock
   always #5 clk_clk = ~clk_clk;

   // Absolute time limit
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Expected sample for the current inputs; literal used where given in the default build.
   task automatic push_exp(input logic [15:0] lit, input bit has_lit);
      longint acc;
      longint m;
      logic [15:0] e;
`ifdef VOICE_MIXER_VOL_SMOOTH_EN
      if (model_gain < int'(master_vol)) model_gain++;
      else if (model_gain > int'(master_vol)) model_gain--;
`else
      model_gain = int'(master_vol);
`endif
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         acc += (longint'(voice[i]) * longint'(note_vol[i])) >>> 16;
      end
      m = (acc * longint'(model_gain)) >>> 8;
      if (m > 32767) m = 32767;
      if (m < -32768) m = -32768;
      e = m[15:0];
`ifndef VOICE_MIXER_VOL_SMOOTH_EN
      if (has_lit) e = lit;
`endif
      exp_q.push_back(e);
   endtask

   // Called at posedge+1: one-cycle tick expected to be accepted.
   task automatic tick_accept(input logic [15:0] lit, input bit has_lit);
      push_exp(lit, has_lit);
      sample_tick = 1'b1;
      @(posedge clk_clk); #1;
      sample_tick = 1'b0;
   endtask

   // Counts cycles from the tick cycle to mix_valid rising.
   task automatic wait_valid(input string tag);
      int n = 0;
      while (bus.mix_valid !== 1'b1 && n < 30) begin
         @(posedge clk_clk); #1;
         n++;
      end
      chk(tag, 16'(n + 1), 16'd7);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.mix_valid !== 1'b0 && n < 40) begin
         @(posedge clk_clk); #1;
         n++;
      end
      chk(tag, {15'd0, bus.mix_valid}, 16'd0);
   endtask

   task automatic set_voices(input logic [15:0] v0, input logic [15:0] v1,
                             input logic [15:0] v2, input logic [15:0] v3,
                             input logic [15:0] g0, input logic [15:0] g1,
                             input logic [15:0] g2, input logic [15:0] g3);
      voice[0] = v0; voice[1] = v1; voice[2] = v2; voice[3] = v3;
      note_vol[0] = g0; note_vol[1] = g1; note_vol[2] = g2; note_vol[3] = g3;
   endtask

   // Scoreboard: compare every transferred sample against the queue head.
   always @(negedge clk_clk) begin
      if (reset_reset_n && bus.mix_valid && bus.mix_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed sample %0d expected none", bus.mix_out);
         end
         if (exp_q.size() != 0) begin
            chk("mix_out", bus.mix_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [15:0] v;
      int quiet;
      bus.mix_ready = 1'b0;
      set_voices(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

      // Reset state
      repeat (3) @(posedge clk_clk);
      @(negedge clk_clk);
      chk("rst_valid", {15'd0, bus.mix_valid}, 16'd0);
      chk("rst_out", bus.mix_out, 16'd0);
      chk("rst_overrun", {15'd0, overrun}, 16'd0);
      chk("rst_state", {13'd0, dbg_state}, 16'd0);
      reset_reset_n = 1'b1;
      @(posedge clk_clk); #1;

      // Gain map: single voice at half scale, unity-ish gains
      bus.mix_ready = 1'b1;
      set_voices(16'd16384, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0);
      master_vol = 8'd255;
      tick_accept(16'd16319, 1'b1);
      wait_valid("lat_gain");
      wait_idle("drain_gain");

      // Positive and negative saturation
      set_voices(16'd32767, 16'd32767, 16'd32767, 16'd32767,
                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      tick_accept(16'd32767, 1'b1);
      wait_valid("lat_sat_pos");
      wait_idle("drain_sat_pos");
      set_voices(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      tick_accept(16'h8000, 1'b1);
      wait_valid("lat_sat_neg");
      wait_idle("drain_sat_neg");

      // Mixed voices, mixed gains
      set_voices(16'd12000, -16'sd7000, 16'd3000, -16'sd20000,
                 16'h8000, 16'hC000, 16'h1234, 16'hFFFF);
      master_vol = 8'd200;
      tick_accept(16'd0, 1'b0);
      wait_valid("lat_mixed");
      wait_idle("drain_mixed");

      // Backpressure with dropped ticks and overrun set/clear
      bus.mix_ready = 1'b0;
      set_voices(-16'sd5000, 16'd9000, 16'd0, 16'd1, 16'hFFFF, 16'h4000, 16'hFFFF, 16'hFFFF);
      master_vol = 8'd128;
      tick_accept(16'd0, 1'b0);
      wait_valid("lat_bp");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_clk); #1;
         sample_tick = (i == 5) || (i == 15);
         clr_overrun = (i == 12) || (i == 15) || (i == 18);
         voice[0] = 16'($urandom_range(0, 65535));
         master_vol = 8'($urandom_range(0, 255));
         @(negedge clk_clk);
         chk("bp_valid", {15'd0, bus.mix_valid}, 16'd1);
         v = (exp_q.size() != 0) ? exp_q[0] : 16'hDEAD;
         chk("bp_out", bus.mix_out, v);
         if (i == 6)  chk("ovr_set", {15'd0, overrun}, 16'd1);
         if (i == 13) chk("ovr_clr", {15'd0, overrun}, 16'd0);
         if (i == 16) chk("ovr_set_wins", {15'd0, overrun}, 16'd1);
         if (i == 19) chk("ovr_clr2", {15'd0, overrun}, 16'd0);
      end
      @(posedge clk_clk); #1;
      sample_tick = 1'b0;
      clr_overrun = 1'b0;
      bus.mix_ready = 1'b1;
      wait_idle("drain_bp");

      // Handshake and tick in the same cycle
      bus.mix_ready = 1'b0;
      set_voices(16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      master_vol = 8'd255;
      tick_accept(16'd0, 1'b0);
      wait_valid("lat_sim_a");
      repeat (3) @(posedge clk_clk);
      #1;
      set_voices(-16'sd1000, 16'd500, 16'd0, 16'd7777, 16'h2000, 16'hFFFF, 16'd0, 16'h9000);
      master_vol = 8'd64;
      bus.mix_ready = 1'b1;
      tick_accept(16'd0, 1'b0);
      wait_valid("lat_sim_b");
      chk("sim_overrun", {15'd0, overrun}, 16'd0);
      wait_idle("drain_sim");

      // Reset asserted during MAC idx=2
      set_voices(16'd8000, 16'd8000, 16'd8000, 16'd8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      master_vol = 8'd255;
      tick_accept(16'd0, 1'b0);
      @(posedge clk_clk); #1;
      @(posedge clk_clk); #1;
      chk("mac_state", {13'd0, dbg_state}, 16'd1);
      reset_reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {15'd0, bus.mix_valid}, 16'd0);
      chk("mid_rst_out", bus.mix_out, 16'd0);
      chk("mid_rst_state", {13'd0, dbg_state}, 16'd0);
      exp_q.delete();
      model_gain = 0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_clk); #1;
         if (bus.mix_valid === 1'b1) quiet++;
      end
      chk("no_partial", 16'(quiet), 16'd0);
      set_voices(16'd300, -16'sd400, 16'd500, -16'sd600, 16'hFFFF, 16'h8000, 16'h4000, 16'h2000);
      tick_accept(16'd0, 1'b0);
      wait_valid("lat_fresh");
      wait_idle("drain_fresh");

      // Master gain step 0 -> 10 from reset
      reset_reset_n = 1'b0;
      #1;
      exp_q.delete();
      model_gain = 0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(posedge clk_clk); #1;
      set_voices(16'd16384, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0);
      master_vol = 8'd10;
      for (int k = 0; k < 10; k++) begin
         tick_accept(16'd639, 1'b1);
         wait_valid("lat_ramp");
         wait_idle("drain_ramp");
      end

      repeat (3) @(posedge clk_clk);
      chk("sb_drained", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
